poly_add: RTL and testbench
===========================

Name: poly_add

Overview:
- Element-wise adder for two Kyber polynomials of N coefficients each.
- Each output coefficient is the full-precision sum a[i]+b[i], one bit wider than the inputs; no modular reduction.
- All N lanes are computed in parallel, with one registered pipeline stage and a valid flag.
- Used inside the polynomial arithmetic datapath (vector/matrix accumulation); reduction mod q is done by a downstream block.

Parameters:
- N, default KYBER_N (256): number of coefficients per polynomial.
- W, default KYBER_POLY_WIDTH (16): input coefficient width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  W x N (unpacked array [N])  operand polynomial A, coefficient i at a[i].
- b  input  W x N (unpacked array [N])  operand polynomial B.
- r  output  (W+1) x N (unpacked array [N])  result polynomial, r[i] = a[i] + b[i].
- out_valid  output  1  r holds the sum of the operands accepted on the previous in_valid cycle.

Interface note: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Arithmetic: r[i] = zero-extend(a[i]) + zero-extend(b[i]), computed in W+1 bits. Operands are unsigned.
  - Never truncates; the maximum value is 2*(2^W-1).
  - No mod-q reduction and no saturation.
- Lanes are fully independent; no carry between coefficients.
- Latency: exactly 1 cycle.
  - On a rising edge with in_valid=1 and rst=0: r <= sums, out_valid <= 1.
- On a rising edge with in_valid=0 and rst=0: r holds its previous value, out_valid <= 0.
- Throughput: one polynomial pair per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure; the downstream block must consume r in the cycle out_valid is high, or rely on r holding until the next accepted input.
- Reset:
  - On a rising edge with rst=1: every r[i] <= 0 and out_valid <= 0, regardless of in_valid.
  - Reset has priority over in_valid.
  - A transaction presented in the same cycle as rst is dropped.
  - Reset asserted mid-stream discards the in-flight result.
- First accepted input after reset deassertion yields out_valid=1 on the next edge.
- X on a or b while in_valid=0 must not propagate into r.

Decomposition:
- Shared package/header (params.vh): KYBER_N, KYBER_POLY_WIDTH, KYBER_Q (unused here, kept for downstream reducer).
  - Shared package also holds typedefs coeff_t (W bits) and coeff_sum_t (W+1 bits).
- One natural sub-module: coeff_add, a single-lane combinational W-bit + W-bit -> (W+1)-bit adder.
  - Instantiated N times via generate; the top level holds the output registers and valid flop.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and random a/b -> all r[i]=0, out_valid=0 throughout; first post-reset cycle is still 0.
- Lane 0: a[0]=0x01A3, b[0]=0xF5AD with in_valid=1 -> next cycle r[0]=0x0F750, out_valid=1.
- Lane 255: a[255]=0x77D8, b[255]=0x347A -> r[255]=0x0AC52.
- Carry-out: all a[i]=0xFFFF, b[i]=0xFFFF -> every r[i]=0x1FFFE.
- Zero: all a[i]=0, b[i]=0 -> every r[i]=0.
- Streaming: two random 4096-bit vector pairs on consecutive cycles, then in_valid=0.
  - out_valid must be 1,1,0.
  - Each r must match a golden per-lane 17-bit sum.
  - r holds the second result after out_valid falls.
- Mid-stream reset: assert rst while a result is pending -> out_valid=0 and r=0 on the next edge; the dropped transaction is never presented.

Source files
------------

// File: rtl/poly_add_pkg.sv
// poly_add_pkg: shared Kyber parameters and coefficient types
package poly_add_pkg;

    localparam int KYBER_N          = 256;
    localparam int KYBER_POLY_WIDTH = 16;
    // Not used by the adder; the downstream mod-q reducer needs it.
    localparam int KYBER_Q          = 3329;

    typedef logic [KYBER_POLY_WIDTH-1:0] coeff_t;
    typedef logic [KYBER_POLY_WIDTH:0]   coeff_sum_t;

endpackage

// File: rtl/poly_add_coeff_add.sv
// coeff_add: single-lane unsigned adder, W + W -> W+1 bits, never truncates
module coeff_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   s
);

    assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/poly_add.sv
// poly_add: N-lane parallel coefficient adder with one registered stage
module poly_add
    import poly_add_pkg::*;
#(
    parameter int N = KYBER_N,
    parameter int W = KYBER_POLY_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a [N],
    input  logic [W-1:0] b [N],
    output logic [W:0]   r [N],
    output logic         out_valid
);

    logic [W:0] sum   [N];
    logic [W:0] r_d   [N];
    logic [W:0] r_q   [N];
    logic       out_valid_d;
    logic       out_valid_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        coeff_add #(.W(W)) u_add (
            .a (a[i]),
            .b (b[i]),
            .s (sum[i])
        );
    end

    // Load new sums only on accepted input so idle-cycle X on a/b never reaches r.
    always_comb begin
        out_valid_d = in_valid;
        for (int i = 0; i < N; i++) begin
            r_d[i] = in_valid ? sum[i] : r_q[i];
        end
    end

    // Result and valid registers; reset wins over any same-cycle transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '{default: '0};
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign r         = r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_poly_add.sv
// tb_poly_add: randomized directed bench for poly_add against an arithmetic model
module tb_poly_add;

    localparam int N = 256;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [W:0]   r [N];
    logic         out_valid;

    logic [W:0]   exp_r [N];
    logic         exp_v;
    int           checks = 0;
    int           errors = 0;

    poly_add #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .r         (r),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
        end
    endtask

    task automatic fill_const(input logic [W-1:0] va, input logic [W-1:0] vb);
        for (int i = 0; i < N; i++) begin
            a[i] = va;
            b[i] = vb;
        end
    endtask

    task automatic fill_x();
        for (int i = 0; i < N; i++) begin
            a[i] = 'x;
            b[i] = 'x;
        end
    endtask

    task automatic check(input string tag);
        int bad;
        bad = -1;
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid got %0b expected %0b", tag, out_valid, exp_v);
        end
        for (int i = 0; i < N; i++) begin
            if (bad < 0 && r[i] !== exp_r[i]) bad = i;
        end
        checks++;
        assert (bad < 0) else begin
            errors++;
            $error("FAIL %s r[%0d] got %h expected %h", tag, bad, r[bad], exp_r[bad]);
        end
    endtask

    // Apply one cycle, advance the model by plain arithmetic, then compare.
    task automatic step(input logic rst_i, input logic v_i, input string tag);
        rst      = rst_i;
        in_valid = v_i;
        @(posedge clk);
        if (rst_i) begin
            for (int i = 0; i < N; i++) exp_r[i] = '0;
            exp_v = 1'b0;
        end else if (v_i) begin
            for (int i = 0; i < N; i++) exp_r[i] = (W + 1)'(int'(a[i]) + int'(b[i]));
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        check(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        fill_random();
        for (int i = 0; i < N; i++) exp_r[i] = '0;
        exp_v = 1'b0;

        fill_random();
        step(1'b1, 1'b1, "reset0");
        fill_random();
        step(1'b1, 1'b1, "reset1");
        fill_x();
        step(1'b0, 1'b0, "post_reset");

        fill_random();
        a[0]   = 16'h01A3; b[0]   = 16'hF5AD;
        a[255] = 16'h77D8; b[255] = 16'h347A;
        step(1'b0, 1'b1, "lanes");
        checks++;
        assert (r[0] === 17'h0F750) else begin
            errors++;
            $error("FAIL lane0 got %h expected %h", r[0], 17'h0F750);
        end
        checks++;
        assert (r[255] === 17'h0AC52) else begin
            errors++;
            $error("FAIL lane255 got %h expected %h", r[255], 17'h0AC52);
        end

        fill_x();
        step(1'b0, 1'b0, "idle_hold");

        fill_const(16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b1, "carry");
        checks++;
        assert (r[17] === 17'h1FFFE) else begin
            errors++;
            $error("FAIL carry_const got %h expected %h", r[17], 17'h1FFFE);
        end

        fill_const(16'h0000, 16'h0000);
        step(1'b0, 1'b1, "zero");

        fill_random();
        step(1'b0, 1'b1, "stream0");
        fill_random();
        step(1'b0, 1'b1, "stream1");
        fill_x();
        step(1'b0, 1'b0, "stream_hold");
        step(1'b0, 1'b0, "stream_hold2");

        fill_random();
        step(1'b0, 1'b1, "pending");
        fill_random();
        step(1'b1, 1'b1, "mid_reset");
        fill_x();
        step(1'b0, 1'b0, "after_mid_reset");

        for (int k = 0; k < 40; k++) begin
            logic rr, vv;
            rr = ($urandom_range(0, 9) == 0);
            vv = $urandom_range(0, 3) != 0;
            if (vv) fill_random(); else fill_x();
            step(rr, vv, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
